// File: rtl/nibble_link_pkg.sv
// rtl/nibble_link_pkg.sv - shared state encoding and framing constants for the nibble serial link
package nibble_link_pkg;

  localparam int   DATA_BITS  = 4;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_t;

  localparam parity_t PARITY_TYPE = PARITY_EVEN;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input parity_t kind);
    return (^d) ^ (kind == PARITY_ODD);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit cycle counter; tick marks the last cycle of a serial bit
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST     = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE_LAST = W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (res || clr || tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST);

  // Lookahead lets the parent register outputs that must line up with the final cycle of a bit.
  assign tick_next = (CLKS_PER_BIT == 1) ||
                     (!res && !clr && !tick && (r_cnt == PRE_LAST));

endmodule

// File: rtl/nibble_tx.sv
// rtl/nibble_tx.sv - nibble serial transmitter: start, 4 data bits LSB first, stop
// Optional even parity bit before stop when NIBBLE_TX_PARITY_EN is defined.
module nibble_tx
  import nibble_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] data_In,
  input  logic       load,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] LAST_IDX = 2'(DATA_BITS - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_idx;
  logic                 r_tx;
  logic                 r_done;
  logic                 w_tick;
  logic                 w_tick_next;
  logic                 w_clr;
`ifdef NIBBLE_TX_PARITY_EN
  logic                 r_parity;
`endif

  // Timer is held at zero while idle so START always gets a full bit period.
  assign w_clr = (r_state == ST_IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .res       (res),
    .clr       (w_clr),
    .tick      (w_tick),
    .tick_next (w_tick_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (load) w_state_next = ST_START;
      ST_START:  if (w_tick) w_state_next = ST_DATA;
`ifdef NIBBLE_TX_PARITY_EN
      ST_DATA:   if (w_tick && (r_idx == LAST_IDX)) w_state_next = ST_PARITY;
      ST_PARITY: if (w_tick) w_state_next = ST_STOP;
`else
      ST_DATA:   if (w_tick && (r_idx == LAST_IDX)) w_state_next = ST_STOP;
`endif
      ST_STOP:   if (w_tick) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_tx     <= IDLE_LEVEL;
      r_done   <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == ST_STOP) && w_tick_next;
      case (r_state)
        ST_IDLE: begin
          r_tx <= IDLE_LEVEL;
          if (load) begin
            r_shift  <= data_In;
            r_idx    <= '0;
            r_tx     <= ~IDLE_LEVEL;
`ifdef NIBBLE_TX_PARITY_EN
            r_parity <= parity_bit(data_In, PARITY_TYPE);
`endif
          end
        end
        ST_START: if (w_tick) r_tx <= r_shift[0];
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (r_idx == LAST_IDX) begin
`ifdef NIBBLE_TX_PARITY_EN
              r_tx <= r_parity;
`else
              r_tx <= IDLE_LEVEL;
`endif
            end else begin
              r_idx <= r_idx + 2'd1;
              r_tx  <= r_shift[1];
            end
          end
        end
`ifdef NIBBLE_TX_PARITY_EN
        ST_PARITY: if (w_tick) r_tx <= IDLE_LEVEL;
`endif
        default: r_tx <= IDLE_LEVEL;
      endcase
    end
  end

  assign tx    = r_tx;
  assign done  = r_done;
  assign ready = (r_state == ST_IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_nibble_tx.sv
// tb/tb_nibble_tx.sv - directed self-checking bench for nibble_tx at CLKS_PER_BIT 4 and 1
module tb_nibble_tx;

`ifdef NIBBLE_TX_PARITY_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int F4 = NB * 4;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] data4, data1;
  logic       load4, load1;
  logic       ready4, tx4, busy4, done4;
  logic       ready1, tx1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .res(res), .data_In(data4), .load(load4),
    .ready(ready4), .tx(tx4), .busy(busy4), .done(done4)
  );

  nibble_tx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .res(res), .data_In(data1), .load(load1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-computed line bits, index 0 = start bit, last index = stop bit.
  function automatic logic [6:0] exp_bits(input logic [3:0] d);
    logic [6:0] r;
    r = '0;
`ifdef NIBBLE_TX_PARITY_EN
    case (d)
      4'hA: r = 7'b1010100;
      4'h7: r = 7'b1101110;
      4'h3: r = 7'b1000110;
      4'hC: r = 7'b1011000;
      4'hF: r = 7'b1011110;
      4'h5: r = 7'b1001010;
      default: r = '0;
    endcase
`else
    case (d)
      4'hA: r = 7'b0110100;
      4'h7: r = 7'b0101110;
      4'h3: r = 7'b0100110;
      4'hC: r = 7'b0111000;
      4'hF: r = 7'b0111110;
      4'h5: r = 7'b0101010;
      default: r = '0;
    endcase
`endif
    return r;
  endfunction

  function automatic logic [127:0] expand(input logic [6:0] bits, input int c);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < NB * c; k++) r[k] = bits[k / c];
    return r;
  endfunction

  task automatic run_frame(input bit sel1, input logic [3:0] d, input string tag);
    int c, f, ndone, done_at;
    logic [127:0] obs;
    logic busy_all;
    c = sel1 ? 1 : 4;
    f = NB * c;
    @(negedge clk);
    check_eq({tag, "_ready_before"}, sel1 ? ready1 : ready4, 1'b1);
    if (sel1) begin data1 = d; load1 = 1'b1; end
    else      begin data4 = d; load4 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    if (sel1) begin load1 = 1'b0; data1 = ~d; end
    else      begin load4 = 1'b0; data4 = ~d; end
    obs = '0; ndone = 0; done_at = 0; busy_all = 1'b1;
    for (int k = 1; k <= f; k++) begin
      if (k > 1) @(negedge clk);
      obs[k-1] = sel1 ? tx1 : tx4;
      if (sel1 ? done1 : done4) begin ndone++; done_at = k; end
      busy_all &= sel1 ? busy1 : busy4;
    end
    @(negedge clk);
    check_eq({tag, "_tx"}, obs, expand(exp_bits(d), c));
    check_eq({tag, "_done_cnt"}, ndone, 1);
    check_eq({tag, "_done_at"}, done_at, f);
    check_eq({tag, "_busy"}, busy_all, 1'b1);
    check_eq({tag, "_ready_after"}, {sel1 ? ready1 : ready4, sel1 ? tx1 : tx4}, 2'b11);
  endtask

  initial begin
    logic [127:0] obs, rdy, exp_tx, exp_rdy;
    int ndone;
    logic tx_all;

    res = 1'b1; load4 = 1'b1; load1 = 1'b1; data4 = 4'hA; data1 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("reset_outs4", {tx4, ready4, busy4, done4}, 4'b1100);
      check_eq("reset_outs1", {tx1, ready1, busy1, done1}, 4'b1100);
    end
    res = 1'b0; load4 = 1'b0; load1 = 1'b0;
    @(negedge clk);
    check_eq("post_reset4", {tx4, ready4, busy4, done4}, 4'b1100);
    check_eq("post_reset1", {tx1, ready1, busy1, done1}, 4'b1100);

    run_frame(1'b0, 4'hA, "f4_a");
    run_frame(1'b0, 4'h7, "f4_7");
    run_frame(1'b1, 4'hF, "f1_f");
    run_frame(1'b1, 4'h5, "f1_5");

    // Load held high, data toggling every cycle: idle cycles fall on 3, C, 3.
    @(negedge clk);
    data4 = 4'h3; load4 = 1'b1;
    @(posedge clk);
    obs = '0; rdy = '0; ndone = 0;
    for (int j = 1; j <= 3 * F4 + 2; j++) begin
      @(negedge clk);
      obs[j-1] = tx4;
      rdy[j-1] = ready4;
      if (done4) ndone++;
      data4 = (j % 2 == 1) ? 4'hC : 4'h3;
    end
    load4 = 1'b0;
    exp_tx = expand(exp_bits(4'h3), 4)
           | (expand(exp_bits(4'hC), 4) << (F4 + 1))
           | (expand(exp_bits(4'h3), 4) << (2 * F4 + 2))
           | (128'd1 << F4) | (128'd1 << (2 * F4 + 1));
    exp_rdy = (128'd1 << F4) | (128'd1 << (2 * F4 + 1));
    check_eq("b2b_tx", obs, exp_tx);
    check_eq("b2b_ready", rdy, exp_rdy);
    check_eq("b2b_done_cnt", ndone, 3);
    @(negedge clk);
    check_eq("b2b_idle_after", {tx4, ready4}, 2'b11);

    // Abort during data bit 2 of 4'h5.
    @(negedge clk);
    data4 = 4'h5; load4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load4 = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("rst_mid_bit2", tx4, 1'b1);
    check_eq("rst_mid_busy", busy4, 1'b1);
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    check_eq("rst_mid_outs", {tx4, ready4, busy4, done4}, 4'b1100);
    ndone = 0; tx_all = 1'b1;
    for (int k = 0; k < F4; k++) begin
      @(negedge clk);
      if (done4) ndone++;
      tx_all &= tx4;
    end
    check_eq("rst_mid_no_done", ndone, 0);
    check_eq("rst_mid_line_idle", tx_all, 1'b1);
    run_frame(1'b0, 4'h5, "f4_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
